// File: rtl/scan_seq_ctrl_if.sv
// Word stream between a word source (bus/FIFO) and the scan sequence controller.
// The source holds word_data/word_valid until a cycle with word_ready high.
interface scan_seq_ctrl_if #(
  parameter int WORD_W = 16
) ();
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/scan_seq_ctrl.sv
// Job controller for a 10010 Moore sequence detector: buffers one word ahead,
// shifts each word MSB-first into the detector, counts detector hits over the
// whole job and signals completion with a one-cycle done pulse.
module scan_seq_ctrl #(
  parameter int WORD_W = 16,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  scan_seq_ctrl_if.slave    word_bus,
  output logic              det_enable,
  output logic              det_reset,
  output logic              det_in,
  input  logic              det_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic              underrun
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR1,
    ST_CLR2,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_DRAIN1,
    ST_DRAIN2,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   acc_cnt_q, acc_cnt_d;    // words accepted into the shadow
  logic [LEN_W-1:0]   ld_cnt_q, ld_cnt_d;      // words moved into the shifter
  logic [WORD_W-1:0]  shadow_q, shadow_d;
  logic               shadow_full_q, shadow_full_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
  logic               underrun_q, underrun_d;

  logic               ready_int;
  logic               xfer;
  logic               do_load;

  // Ready only while a job is running, the shadow slot is free and words remain.
  assign busy              = (state_q != ST_IDLE);
  assign ready_int         = busy & ~shadow_full_q & (acc_cnt_q < len_q);
  assign word_bus.word_ready = ready_int;
  assign xfer              = word_bus.word_valid & ready_int;

  // Detector controls decode purely from registered state and shift register.
  assign det_enable = (state_q == ST_CLR1) | (state_q == ST_CLR2) | (state_q == ST_SHIFT);
  assign det_reset  = (state_q == ST_CLR1) | (state_q == ST_CLR2);
  assign det_in     = (state_q == ST_SHIFT) & shreg_q[WORD_W-1];
  assign done       = (state_q == ST_DONE);
  assign hit_count  = hit_count_q;
  assign underrun   = underrun_q;

  // Next-state, shadow fill, shifter and hit counter updates.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    acc_cnt_d     = acc_cnt_q;
    ld_cnt_d      = ld_cnt_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    shreg_d       = shreg_q;
    bit_idx_d     = bit_idx_q;
    hit_count_d   = hit_count_q;
    underrun_d    = underrun_q;
    do_load       = 1'b0;

    // A transfer needs an empty shadow, so it never collides with a load below.
    if (xfer) begin
      shadow_d      = word_bus.word_data;
      shadow_full_d = 1'b1;
      acc_cnt_d     = acc_cnt_q + 1'b1;
    end

    // det_out trails det_in by two cycles, so the drain states still count.
    if ((state_q == ST_SHIFT || state_q == ST_GAP ||
         state_q == ST_DRAIN1 || state_q == ST_DRAIN2) &&
        det_out && (hit_count_q != {CNT_W{1'b1}})) begin
      hit_count_d = hit_count_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d         = len;
          acc_cnt_d     = '0;
          ld_cnt_d      = '0;
          shadow_full_d = 1'b0;
          hit_count_d   = '0;
          underrun_d    = 1'b0;
          state_d       = ST_CLR1;
        end
      end
      ST_CLR1: state_d = ST_CLR2;
      ST_CLR2: state_d = (len_q == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: begin
        if (shadow_full_q) begin
          do_load = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_idx_d = bit_idx_q - 1'b1;
        if (bit_idx_q == '0) begin
          if (ld_cnt_q == len_q) begin
            state_d = ST_DRAIN1;
          end else if (shadow_full_q) begin
            do_load = 1'b1;
          end else begin
            underrun_d = 1'b1;
            state_d    = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (shadow_full_q) begin
          do_load = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_DRAIN1: state_d = ST_DRAIN2;
      ST_DRAIN2: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Move the buffered word into the shifter, MSB goes out first.
    if (do_load) begin
      shreg_d       = shadow_q;
      shadow_full_d = 1'b0;
      bit_idx_d     = LAST_IDX;
      ld_cnt_d      = ld_cnt_q + 1'b1;
    end
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      acc_cnt_q     <= '0;
      ld_cnt_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      shreg_q       <= '0;
      bit_idx_q     <= '0;
      hit_count_q   <= '0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      acc_cnt_q     <= acc_cnt_d;
      ld_cnt_q      <= ld_cnt_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      shreg_q       <= shreg_d;
      bit_idx_q     <= bit_idx_d;
      hit_count_q   <= hit_count_d;
      underrun_q    <= underrun_d;
    end
  end

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl. Two controllers (8-bit and 2-bit hit
// counters) see identical stimulus, each driving its own 10010 detector model.
module tb_scan_seq_ctrl;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        start  = 1'b0;
  logic [7:0]  len    = 8'd0;
  logic [15:0] wdata  = 16'd0;
  logic        wvalid = 1'b0;

  logic       det_en_a, det_rst_a, det_in_a, busy_a, done_a, und_a;
  logic       det_en_b, det_rst_b, det_in_b, busy_b, done_b, und_b;
  logic [7:0] hit_a;
  logic [1:0] hit_b;
  logic       det_out_a = 1'b0;
  logic       det_out_b = 1'b0;
  logic [2:0] st_a = 3'd0;
  logic [2:0] st_b = 3'd0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int lat = 0;
  int busy_drop = 0;
  int rdy_seen = 0;
  logic job_active = 1'b0;

  scan_seq_ctrl_if #(.WORD_W(16)) bus_a ();
  scan_seq_ctrl_if #(.WORD_W(16)) bus_b ();

  assign bus_a.word_data  = wdata;
  assign bus_a.word_valid = wvalid;
  assign bus_b.word_data  = wdata;
  assign bus_b.word_valid = wvalid;

  scan_seq_ctrl #(.WORD_W(16), .LEN_W(8), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start), .len(len), .word_bus(bus_a),
    .det_enable(det_en_a), .det_reset(det_rst_a), .det_in(det_in_a),
    .det_out(det_out_a), .busy(busy_a), .done(done_a), .hit_count(hit_a),
    .underrun(und_a)
  );

  scan_seq_ctrl #(.WORD_W(16), .LEN_W(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .len(len), .word_bus(bus_b),
    .det_enable(det_en_b), .det_reset(det_rst_b), .det_in(det_in_b),
    .det_out(det_out_b), .busy(busy_b), .done(done_b), .hit_count(hit_b),
    .underrun(und_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Non-overlapping 10010 Moore detector; state 5 is the match state and the
  // output is registered once more, giving two cycles from bit to det_out.
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0: return b ? 3'd1 : 3'd0;
      3'd1: return b ? 3'd1 : 3'd2;
      3'd2: return b ? 3'd1 : 3'd3;
      3'd3: return b ? 3'd4 : 3'd0;
      3'd4: return b ? 3'd1 : 3'd5;
      default: return b ? 3'd1 : 3'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!det_en_a || det_rst_a) st_a <= 3'd0;
    else                        st_a <= det_next(st_a, det_in_a);
    det_out_a <= (st_a == 3'd5);
  end

  always @(posedge clk) begin
    if (!det_en_b || det_rst_b) st_b <= 3'd0;
    else                        st_b <= det_next(st_b, det_in_b);
    det_out_b <= (st_b == 3'd5);
  end

  always @(negedge clk) begin
    if (job_active && !busy_a)         busy_drop <= busy_drop + 1;
    if (job_active && bus_a.word_ready) rdy_seen <= rdy_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    job_active = 1'b1;
    $display("[TB] start len=%0d at cycle %0d", l, cyc);
  endtask

  task automatic send_word(input logic [15:0] d, input string tag);
    int n;
    n = 0;
    wdata  = d;
    wvalid = 1'b1;
    while (!bus_a.word_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, (n < 200) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    $display("[TB] word %h sent after %0d wait cycles", d, n);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done_a && n < 500) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - t0;
    job_active = 1'b0;
    check({tag, "_done_seen"}, {31'd0, done_a}, 32'd1);
    check({tag, "_busy_in_done"}, {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {30'd0, done_a, busy_a}, 32'd0);
    $display("[TB] job done latency=%0d hits=%0d/%0d underrun=%0b", lat, hit_a, hit_b, und_a);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outs",
          {17'd0, busy_a, done_a, bus_a.word_ready, det_en_a, det_rst_a, det_in_a, und_a, hit_a},
          32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Job 1: len=1, 16'h9000 -> one hit
    busy_drop = 0;
    do_start(8'd1);
    send_word(16'h9000, "j1");
    wait_done("j1");
    check("j1_latency", lat, 32'd21);
    check("j1_hit_a", {24'd0, hit_a}, 32'd1);
    check("j1_hit_b", {30'd0, hit_b}, 32'd1);
    check("j1_underrun", {31'd0, und_a}, 32'd0);
    check("j1_busy_drop", busy_drop, 32'd0);

    // Job 2: gapless 9249, 0000 -> two in-word hits plus one across the boundary
    do_start(8'd2);
    send_word(16'h9249, "j2w0");
    send_word(16'h0000, "j2w1");
    wait_done("j2");
    check("j2_latency", lat, 32'd37);
    check("j2_hit_a", {24'd0, hit_a}, 32'd3);
    check("j2_hit_b", {30'd0, hit_b}, 32'd3);
    check("j2_underrun", {31'd0, und_a}, 32'd0);

    // Job 3: second word late -> GAP, boundary hit lost
    do_start(8'd2);
    send_word(16'h9249, "j3w0");
    repeat (23) @(negedge clk);
    check("j3_gap_det_en", {31'd0, det_en_a}, 32'd0);
    check("j3_gap_busy", {31'd0, busy_a}, 32'd1);
    check("j3_gap_underrun", {31'd0, und_a}, 32'd1);
    send_word(16'h0000, "j3w1");
    wait_done("j3");
    check("j3_latency", lat, 32'd44);
    check("j3_hit_a", {24'd0, hit_a}, 32'd2);
    check("j3_hit_b", {30'd0, hit_b}, 32'd2);
    repeat (3) @(negedge clk);
    check("j3_hold", {23'd0, und_a, hit_a}, {23'd0, 1'b1, 8'd2});

    // Job 4: len=0 -> CLR1, CLR2, DONE without ever requesting a word
    rdy_seen = 0;
    do_start(8'd0);
    wait_done("j4");
    check("j4_latency", lat, 32'd2);
    check("j4_hit_a", {24'd0, hit_a}, 32'd0);
    check("j4_underrun", {31'd0, und_a}, 32'd0);
    check("j4_ready_seen", rdy_seen, 32'd0);

    // Job 5: four gapless 9249 words -> 8 hits, 2-bit counter saturates at 3;
    // a start pulse mid-job must be ignored
    do_start(8'd4);
    send_word(16'h9249, "j5w0");
    send_word(16'h9249, "j5w1");
    start = 1'b1;
    len   = 8'd7;
    @(negedge clk);
    start = 1'b0;
    send_word(16'h9249, "j5w2");
    send_word(16'h9249, "j5w3");
    wait_done("j5");
    check("j5_latency", lat, 32'd69);
    check("j5_hit_a", {24'd0, hit_a}, 32'd8);
    check("j5_hit_b_sat", {30'd0, hit_b}, 32'd3);
    check("j5_underrun", {31'd0, und_a}, 32'd0);
    check("j5_idle_ready", {31'd0, bus_a.word_ready}, 32'd0);

    // Job 6: reset asserted mid-SHIFT clears everything at once
    do_start(8'd1);
    send_word(16'h9000, "j6");
    repeat (11) @(negedge clk);
    check("j6_mid_hit", {24'd0, hit_a}, 32'd1);
    check("j6_mid_det_en", {31'd0, det_en_a}, 32'd1);
    #2 reset = 1'b0;
    #1;
    job_active = 1'b0;
    check("j6_async_clear",
          {17'd0, busy_a, done_a, bus_a.word_ready, det_en_a, det_rst_a, det_in_a, und_a, hit_a},
          32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("j6_post_reset_idle", {24'd0, busy_a, done_a, hit_a[5:0]}, 32'd0);

    // Job 7: clean rerun after the abort
    busy_drop = 0;
    do_start(8'd1);
    send_word(16'h9000, "j7");
    wait_done("j7");
    check("j7_latency", lat, 32'd21);
    check("j7_hit_a", {24'd0, hit_a}, 32'd1);
    check("j7_underrun", {31'd0, und_a}, 32'd0);
    check("j7_busy_drop", busy_drop, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
